// File: rtl/lsu_mem_master.sv
// Load/store initiator: one validated request per transaction, a single-cycle memory strobe and a registered response.
// Optional alignment trap is built in when LSU_MISALIGN_TRAP_EN is defined.
//
// state | meaning
// IDLE  | req_ready high; accept and validate a request
// ISSUE | memory strobe high; memory samples at the closing edge
// WAIT  | load data arrives from memory; captured into resp_rdata
// RESP  | resp_valid high; hold resp_rdata/resp_err until resp_ready
module lsu_mem_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic [2:0]          mem_funct3_q, mem_funct3_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                we_q, we_d;

  logic funct3_bad;
  logic addr_bad;
  logic misaligned;
  logic req_err;

  always_comb begin
    if (req_we) funct3_bad = (req_funct3 > 3'd2);
    else        funct3_bad = (req_funct3 == 3'd3) || (req_funct3 > 3'd5);
  end

  // Addresses beyond the memory window are rejected rather than aliased.
  assign addr_bad = |req_addr[31:ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_err = funct3_bad || addr_bad || misaligned;

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_funct3_d = mem_funct3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    we_d         = we_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d  = 1'b0;
          resp_rdata_d = '0;
          if (req_err) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else begin
            resp_err_d   = 1'b0;
            mem_read_d   = ~req_we;
            mem_write_d  = req_we;
            mem_funct3_d = req_funct3;
            mem_addr_d   = req_addr[ADDR_W-1:0];
            mem_wdata_d  = req_wdata;
            we_d         = req_we;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        resp_rdata_d = mem_rdata;
        state_d      = RESP;
      end
      RESP: begin
        // resp_valid rises one edge after entry; the handshake only counts once it is visible.
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_funct3_q <= 3'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      mem_funct3_q <= mem_funct3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      we_q         <= we_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign mem_funct3 = mem_funct3_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-addressed synchronous memory model.
// Misalignment expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  mem_funct3;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [0:1023];
  int tests_run = 0;
  int tests_failed = 0;

  lsu_mem_master #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_load(input logic [9:0] a, input logic [2:0] f);
    logic [31:0] w;
    w = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    case (f)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory samples strobes at the edge closing ISSUE; read data is registered.
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'd0) mem[mem_addr + 10'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'd2) begin
        mem[mem_addr + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr + 10'd3] <= mem_wdata[31:24];
      end
    end
    if (mem_read) mem_rdata <= mem_load(mem_addr, mem_funct3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_rdp, input int exp_wrp);
    int cyc;
    int rdp;
    int wrp;
    logic [9:0] seen_addr;
    @(negedge clk);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    cyc = 0; rdp = 0; wrp = 0; seen_addr = '0;
    while (resp_valid !== 1'b1 && cyc < 20) begin
      if (mem_read === 1'b1) rdp++;
      if (mem_write === 1'b1) wrp++;
      if (mem_read === 1'b1 || mem_write === 1'b1) seen_addr = mem_addr;
      if (cyc == 0) chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_strobe_excl"}, {31'd0, mem_read & mem_write}, 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    chk({tag, "_read_pulses"}, rdp, exp_rdp);
    chk({tag, "_write_pulses"}, wrp, exp_wrp);
    if (exp_rdp + exp_wrp > 0) chk({tag, "_mem_addr"}, {22'd0, seen_addr}, {22'd0, addr[9:0]});
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem_rdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_funct3", {29'd0, mem_funct3}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    xact("sw_10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
    handshake("sw_10");
    xact("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1, 0);
    handshake("lw_10");

    xact("sb_21", 1'b1, 3'd0, 32'h21, 32'h80, 2, 32'h0, 1'b0, 0, 1);
    handshake("sb_21");
    xact("lb_21", 1'b0, 3'd0, 32'h21, 32'h0, 3, 32'hFFFFFF80, 1'b0, 1, 0);
    handshake("lb_21");
    xact("lbu_21", 1'b0, 3'd4, 32'h21, 32'h0, 3, 32'h00000080, 1'b0, 1, 0);
    handshake("lbu_21");
    xact("sh_22", 1'b1, 3'd1, 32'h22, 32'h8001, 2, 32'h0, 1'b0, 0, 1);
    handshake("sh_22");
    xact("lh_22", 1'b0, 3'd1, 32'h22, 32'h0, 3, 32'hFFFF8001, 1'b0, 1, 0);
    handshake("lh_22");
    xact("lhu_22", 1'b0, 3'd5, 32'h22, 32'h0, 3, 32'h00008001, 1'b0, 1, 0);
    handshake("lhu_22");

    xact("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    handshake("ld_f3_3");
    xact("st_f3_4", 1'b1, 3'd4, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    handshake("st_f3_4");
    xact("lw_400", 1'b0, 3'd2, 32'h400, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    handshake("lw_400");

`ifdef LSU_MISALIGN_TRAP_EN
    xact("lw_13", 1'b0, 3'd2, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, 0);
`else
    // Bytes 0x13..0x16 = DE 00 00 00 after the word store at 0x10.
    xact("lw_13", 1'b0, 3'd2, 32'h13, 32'h0, 3, 32'h000000DE, 1'b0, 1, 0);
`endif
    handshake("lw_13");

    resp_ready = 1'b0;
    xact("bp_lw", 1'b0, 3'd2, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_valid_held", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata_held", resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_no_write", {31'd0, mem_write}, 32'd0);
    end
    req_valid = 1'b0;
    handshake("bp");
    xact("bp_verify", 1'b0, 3'd2, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1, 0);
    handshake("bp_verify");

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_mid_write_pre", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write_drop", {31'd0, mem_write}, 32'd0);
    chk("rst_mid_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("rst_mid_no_write", {31'd0, mem_write}, 32'd0);
    end
    xact("rst_mid_lw", 1'b0, 3'd2, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1, 0);
    handshake("rst_mid_lw");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
